// File: rtl/pack_hdmi_points.sv
// rtl/pack_hdmi_points.sv - LiDAR point packer into a 24-bit HDMI pixel stream
//
// Purpose: queues LiDAR points in a small FIFO and emits one point per
// five-pixel slot of active video (4 data pixels + 1 pad pixel), with full
// raster timing. Empty slots carry a filler point whose flag is 0.
//
// Optional feature macro: PACK_HDMI_TESTPATTERN_EN adds test_en and a frame
// counter; while test_en is high each slot carries a synthetic point instead
// of popping the FIFO.
//
// Ports:
//   clk, rst_n                      pixel clock, synchronous active-low reset
//   pt_valid / pt_ready             point input handshake
//   x_in, y_in, z_in                signed 16-bit coordinates
//   intens_in, flag_in              intensity and point-valid flag
//   pixel_out                       {R, G, B}, R always 0
//   de_out, hsync_out, vsync_out    active-high video controls
//   test_en                         test pattern select (macro builds only)

module pack_hdmi_points #(
  parameter int H_ACTIVE   = 1280,
  parameter int H_FP       = 110,
  parameter int H_SYNC     = 40,
  parameter int H_BP       = 220,
  parameter int V_ACTIVE   = 720,
  parameter int V_FP       = 5,
  parameter int V_SYNC     = 5,
  parameter int V_BP       = 20,
  parameter int FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pt_valid,
  output logic        pt_ready,
  input  logic [15:0] x_in,
  input  logic [15:0] y_in,
  input  logic [15:0] z_in,
  input  logic [7:0]  intens_in,
  input  logic        flag_in,
  output logic [23:0] pixel_out,
  output logic        de_out,
  output logic        hsync_out,
  output logic        vsync_out
`ifdef PACK_HDMI_TESTPATTERN_EN
  ,
  input  logic        test_en
`endif
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int AW      = $clog2(FIFO_DEPTH);

  typedef struct packed {
    logic [15:0] x;
    logic [15:0] y;
    logic [15:0] z;
    logic [7:0]  intens;
    logic        flag;
  } point_t;

  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic [2:0]    phase;

  point_t        mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  point_t        shadow;

  logic          active;
  logic          h_last;
  logic          v_last;
  logic          slot_start;
  logic          fifo_empty;
  logic          push;
  logic          pop;
  logic          use_pattern;
  point_t        load_pt;
  point_t        cur_pt;
  logic [23:0]   pix;
  logic          hsync_c;
  logic          vsync_c;

  assign active     = (int'(h_cnt) < H_ACTIVE) && (int'(v_cnt) < V_ACTIVE);
  assign h_last     = (int'(h_cnt) == H_TOTAL - 1);
  assign v_last     = (int'(v_cnt) == V_TOTAL - 1);
  assign hsync_c    = (int'(h_cnt) >= H_ACTIVE + H_FP) &&
                      (int'(h_cnt) <  H_ACTIVE + H_FP + H_SYNC);
  assign vsync_c    = (int'(v_cnt) >= V_ACTIVE + V_FP) &&
                      (int'(v_cnt) <  V_ACTIVE + V_FP + V_SYNC);
  assign slot_start = active && (phase == 3'd0);
  assign fifo_empty = (count == '0);

  assign pt_ready   = (count != (AW+1)'(FIFO_DEPTH)) && rst_n;
  assign push       = pt_valid && pt_ready;
  // Uses the registered count, so a push landing on the same edge as a
  // slot start into an empty FIFO is not visible to that slot.
  assign pop        = slot_start && !fifo_empty && !use_pattern;

`ifdef PACK_HDMI_TESTPATTERN_EN
  logic [15:0] slot_idx;
  logic [15:0] frame_cnt;

  assign use_pattern = test_en;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      slot_idx  <= '0;
      frame_cnt <= '0;
    end else begin
      if (h_last) begin
        slot_idx <= '0;
        if (v_last) frame_cnt <= frame_cnt + 1'b1;
      end else if (active && phase == 3'd4) begin
        slot_idx <= slot_idx + 1'b1;
      end
    end
  end

  always_comb begin
    load_pt = '0;
    if (use_pattern) begin
      load_pt.x      = slot_idx;
      load_pt.y      = 16'(v_cnt);
      load_pt.z      = frame_cnt;
      load_pt.intens = 8'hA5;
      load_pt.flag   = 1'b1;
    end else if (!fifo_empty) begin
      load_pt = mem[rd_ptr];
    end
  end
`else
  assign use_pattern = 1'b0;

  always_comb begin
    load_pt = '0;
    if (!fifo_empty) load_pt = mem[rd_ptr];
  end
`endif

  // The slot's first pixel comes straight from the freshly loaded point;
  // later pixels of the slot read the shadow captured at slot start.
  assign cur_pt = slot_start ? load_pt : shadow;

  always_comb begin
    pix = '0;
    case (phase)
      3'd0:    pix = {8'h00, cur_pt.x[15:8], cur_pt.z[15:8]};
      3'd1:    pix = {8'h00, cur_pt.x[7:0],  cur_pt.z[7:0]};
      3'd2:    pix = {8'h00, cur_pt.y[15:8], cur_pt.intens};
      3'd3:    pix = {8'h00, cur_pt.y[7:0],  7'b0, cur_pt.flag};
      default: pix = '0;
    endcase
  end

  // Raster counters and slot phase. Phase returns to 0 at every line start,
  // so a slot never spans two lines.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
      phase <= '0;
    end else begin
      if (h_last) begin
        h_cnt <= '0;
        phase <= '0;
        v_cnt <= v_last ? '0 : v_cnt + 1'b1;
      end else begin
        h_cnt <= h_cnt + 1'b1;
        if (active) phase <= (phase == 3'd4) ? 3'd0 : phase + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{x: x_in, y: y_in, z: z_in, intens: intens_in, flag: flag_in};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shadow <= '0;
    end else if (slot_start) begin
      shadow <= load_pt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pixel_out <= '0;
      de_out    <= 1'b0;
      hsync_out <= 1'b0;
      vsync_out <= 1'b0;
    end else begin
      pixel_out <= active ? pix : 24'h000000;
      de_out    <= active;
      hsync_out <= hsync_c;
      vsync_out <= vsync_c;
    end
  end

endmodule

// File: doc/pack_hdmi_points.md
# pack_hdmi_points

Transmit-side packer that serialises LiDAR points (x, y, z, intensity, valid flag) into a 24-bit HDMI video pixel stream with full raster timing (de, hsync, vsync). Sits in the FPGA-to-host direction of the LiDAR HDMI link. It produces exactly the 4-pixel-per-point encoding the HDMI point parser consumes, plus one pad pixel per slot. Points enter through a valid/ready handshake into an internal FIFO. Slots with no queued point carry a filler point whose flag is 0.

## Interface
- H_ACTIVE, 1280, active pixels per line; must be a multiple of 5
- H_FP, 110, horizontal front porch, pixels
- H_SYNC, 40, hsync width, pixels
- H_BP, 220, horizontal back porch, pixels
- V_ACTIVE, 720, active lines
- V_FP, 5, vertical front porch, lines
- V_SYNC, 5, vsync width, lines
- V_BP, 20, vertical back porch, lines
- FIFO_DEPTH, 16, point FIFO entries; power of two, ≥2

Ports:
- clk  in  1  pixel clock; sole clock
- rst_n  in  1  synchronous, active-low reset
- pt_valid  in  1  input point valid
- pt_ready  out  1  point accepted when pt_valid && pt_ready at posedge
- x_in, y_in, z_in  in  16 each  signed coordinates
- intens_in  in  8  intensity
- flag_in  in  1  point-valid flag
- pixel_out  out  24  {R, G, B}
- de_out, hsync_out, vsync_out  out  1 each  active-high video controls
- test_en  in  1  present only with PACK_HDMI_TESTPATTERN_EN

## Operation
- Counters: h_cnt runs 0..H_TOTAL-1 (H_TOTAL = sum of H params); v_cnt increments on h wrap, 0..V_TOTAL-1, then wraps to 0.
- active = h_cnt < H_ACTIVE && v_cnt < V_ACTIVE.
- hsync when h_cnt ∈ [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC). vsync for whole lines with v_cnt ∈ [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC).
- Slot phase 0..4: cleared to 0 at h_cnt==0, +1 per active pixel, wraps 4→0. Slots never straddle lines.
- Phase 0 while active:
  - If FIFO is non-empty, pop the head into a shadow register.
  - Otherwise load the shadow with zeros (filler, flag 0).
  - The phase-0 pixel is taken directly from the popped or filler value.
- Pixel encoding (R always 0x00; G=[15:8], B=[7:0]):
  - phase 0: G = x[15:8], B = z[15:8]
  - phase 1: G = x[7:0], B = z[7:0]
  - phase 2: G = y[15:8], B = intens
  - phase 3: G = y[7:0], B = {7'b0, flag}
  - phase 4: 0x000000 (pad, absorbs the parser's idle cycle)
- Outside active: pixel_out = 0, de_out = 0.
- FIFO:
  - pt_ready = (count != FIFO_DEPTH) && rst_n.
  - Push and pop in the same cycle: count unchanged.
  - Push into an empty FIFO coinciding with a phase-0 pop: the pop sees empty and emits filler; the point goes out in the next slot.
- Backpressure only; points are never dropped.

## Timing
- All outputs registered. Counter state at cycle n appears on the outputs at cycle n+1.
- Push-to-wire: a point pushed at cycle n into an empty FIFO can be popped no earlier than cycle n+1.
- rst_n low at a posedge:
  - counters, phase, FIFO pointers and count clear; shadow clears
  - pixel_out = 0, de_out = hsync_out = vsync_out = 0
  - pt_ready = 0 while rst_n is low
- First posedge after release: counters at (0,0). The next edge outputs de_out = 1 with phase-0 pixel.
- Reset mid-line or mid-slot: the in-flight slot is abandoned and queued points are discarded. The raster restarts at (0,0); no partial slot is resumed.
- Throughput: one point per 5 active pixels; H_ACTIVE/5 points per line.

## Configuration
- PACK_HDMI_TESTPATTERN_EN defined: adds port test_en, plus a 16-bit frame counter that increments on v wrap.
  - While test_en = 1, phase 0 ignores the FIFO (no pop) and loads: x = slot index within line, y = v_cnt, z = frame counter, intens = 0xA5, flag = 1.
  - pt_ready behaves normally.
- Undefined: no test_en port, no frame counter; FIFO/filler data only.

## Test plan
- Small raster (H_ACTIVE=10, H_FP=2, H_SYNC=3, H_BP=5, V_ACTIVE=2, V_FP=1, V_SYNC=1, V_BP=1), FIFO empty:
  - de_out high for 10 cycles per line, 2 lines per frame
  - hsync_out high 3 cycles, starting 2 cycles after de_out falls
  - vsync_out high for exactly 1 line (20 cycles)
  - pixel_out all 0
- Push x=0x1234, y=0x5678, z=0x9ABC, intens=0x5A, flag=1 during blanking:
  - first slot emits 0x00129A, 0x0034BC, 0x00565A, 0x007801, 0x000000
  - next slot is filler (5× 0x000000)
- Hold pt_valid continuously from reset release:
  - pt_ready drops after 16 accepts in blanking
  - during active, exactly one accept per 5 pixels
  - output order matches input order, with no loss
- Push into an empty FIFO in the same cycle as a phase-0 pop: that slot is filler; the point appears in the following slot.
- Assert rst_n low for 1 cycle at phase 2 with 3 points queued:
  - outputs 0 next edge, FIFO empty
  - raster restarts at (0,0) with filler slots
- Macro defined, test_en=1: second slot of line 1 in frame 0 emits x=1, y=1, z=0, intens=0xA5, flag=1; FIFO count unchanged.
